// File: rtl/muldiv_seq_if.sv
// Request/result bundle for the multi-cycle multiply/divide sequencer.
// The master issues start/ALU_FUNC/a/b; the slave returns busy/done/out/div_by_zero.
interface muldiv_seq_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic [2:0]         ALU_FUNC;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] out;
  logic               div_by_zero;

  modport master (
    output start, ALU_FUNC, a, b,
    input  busy, done, out, div_by_zero
  );

  modport slave (
    input  start, ALU_FUNC, a, b,
    output busy, done, out, div_by_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned shift-add multiplier / restoring divider behind a start/done handshake.
// Latency WIDTH+1 cycles from accept to done (divide-by-zero: 1); busy stalls the pipe, requests while busy are dropped.
// MULDIV_EARLY_OUT_EN: multiply finishes as soon as the remaining multiplier bits are all zero.
module muldiv_seq #(
  parameter int WIDTH = 16
) (
  input logic          clk,
  input logic          rst,
  muldiv_seq_if.slave  bus
);
  localparam logic [2:0] FUNC_MUL = 3'b100;
  localparam logic [2:0] FUNC_DIV = 3'b101;
  localparam int         CW       = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  // acc holds the product during MUL and {remainder, quotient} during DIV
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   opb;
  logic [CW-1:0]      iter;

  logic               accept;
  logic               last_iter;
  logic               mul_finish;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   opb_shr;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    accept    = bus.start
              && ((bus.ALU_FUNC == FUNC_MUL) || (bus.ALU_FUNC == FUNC_DIV))
              && ((state == IDLE) || (state == DONE));
    last_iter = (iter == CW'(WIDTH - 1));
    mul_next  = opb[0] ? (acc + mcand) : acc;
    opb_shr   = opb >> 1;
`ifdef MULDIV_EARLY_OUT_EN
    mul_finish = last_iter || (opb_shr == '0);
`else
    mul_finish = last_iter;
`endif
    // Shifted remainder is WIDTH+1 bits; when it is >= divisor the difference fits in WIDTH bits
    div_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_sh >= {1'b0, opb});
    div_diff  = div_sh[WIDTH-1:0] - opb;
    div_next  = div_ge ? {div_diff,          acc[WIDTH-2:0], 1'b1}
                       : {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.out         <= '0;
      bus.div_by_zero <= 1'b0;
      acc             <= '0;
      mcand           <= '0;
      opb             <= '0;
      iter            <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        MUL: begin
          acc   <= mul_next;
          mcand <= mcand << 1;
          opb   <= opb_shr;
          iter  <= iter + 1'b1;
          if (mul_finish) begin
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.out         <= mul_next;
            bus.div_by_zero <= 1'b0;
          end
        end

        DIV: begin
          acc  <= div_next;
          iter <= iter + 1'b1;
          if (last_iter) begin
            state           <= DONE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.out         <= div_next;
            bus.div_by_zero <= 1'b0;
          end
        end

        IDLE, DONE: begin
          if (accept) begin
            iter  <= '0;
            mcand <= {{WIDTH{1'b0}}, bus.a};
            opb   <= bus.b;
            if (bus.ALU_FUNC == FUNC_MUL) begin
              acc <= '0;
`ifdef MULDIV_EARLY_OUT_EN
              if (bus.b == '0) begin
                state           <= DONE;
                bus.done        <= 1'b1;
                bus.out         <= '0;
                bus.div_by_zero <= 1'b0;
              end else begin
                state    <= MUL;
                bus.busy <= 1'b1;
              end
`else
              state    <= MUL;
              bus.busy <= 1'b1;
`endif
            end else begin
              acc <= {{WIDTH{1'b0}}, bus.a};
              if (bus.b == '0) begin
                state           <= DONE;
                bus.done        <= 1'b1;
                bus.out         <= {bus.a, {WIDTH{1'b1}}};
                bus.div_by_zero <= 1'b1;
              end else begin
                state    <= DIV;
                bus.busy <= 1'b1;
              end
            end
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, packing, divide-by-zero, dropped requests, back-to-back and reset abort.
// Latency figures count clock edges after the accept edge until done is seen (done in cycle k+1+lat).
module tb_muldiv_seq;
  localparam int W = 16;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   lat;
  int   bcnt;
  int   seen;

  muldiv_seq_if #(.WIDTH(W)) bus_if ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Multiply iterations expected for multiplier bv
  function automatic int mul_lat(input logic [W-1:0] bv);
    int msb = 0;
    for (int i = 0; i < W; i++) if (bv[i]) msb = i + 1;
    return EARLY ? msb : W;
  endfunction

  task automatic drive(input logic [2:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
    bus_if.start    = 1'b1;
    bus_if.ALU_FUNC = f;
    bus_if.a        = av;
    bus_if.b        = bv;
  endtask

  task automatic wait_done(output int l, output int bc);
    l  = 0;
    bc = 0;
    while (bus_if.done !== 1'b1 && l < 40) begin
      if (bus_if.busy === 1'b1) bc++;
      tick();
      l++;
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int l, output int bc);
    drive(f, av, bv);
    tick();
    bus_if.start = 1'b0;
    wait_done(l, bc);
  endtask

  initial begin
    bus_if.start    = 1'b0;
    bus_if.ALU_FUNC = 3'b000;
    bus_if.a        = '0;
    bus_if.b        = '0;
    tick();
    tick();
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    check("rst_out", bus_if.out, 0);
    check("rst_dbz", bus_if.div_by_zero, 0);
    rst = 1'b0;
    tick();

    run_op(3'b100, 16'h1234, 16'h0010, lat, bcnt);
    check("mul1_out", bus_if.out, 32'h0001_2340);
    check("mul1_lat", lat, mul_lat(16'h0010));
    check("mul1_busy_cycles", bcnt, mul_lat(16'h0010));
    tick();
    check("mul1_done_pulse", bus_if.done, 0);
    check("mul1_busy_after", bus_if.busy, 0);

    run_op(3'b100, 16'hFFFF, 16'hFFFF, lat, bcnt);
    check("mul_max_out", bus_if.out, 32'hFFFE_0001);
    check("mul_max_dbz", bus_if.div_by_zero, 0);
    check("mul_max_lat", lat, W);
    tick();

    run_op(3'b100, 16'hFFFF, 16'h0003, lat, bcnt);
    check("mul_b3_out", bus_if.out, 32'h0002_FFFD);
    check("mul_b3_lat", lat, EARLY ? 2 : W);
    tick();

    run_op(3'b101, 16'd100, 16'd7, lat, bcnt);
    check("div_100_7_out", bus_if.out, 32'h0002_000E);
    check("div_100_7_lat", lat, W);
    check("div_100_7_dbz", bus_if.div_by_zero, 0);
    tick();

    run_op(3'b101, 16'h0055, 16'h0000, lat, bcnt);
    check("div0_out", bus_if.out, 32'h0055_FFFF);
    check("div0_dbz", bus_if.div_by_zero, 1);
    check("div0_lat", lat, 0);
    check("div0_busy_cycles", bcnt, 0);
    tick();
    check("div0_dbz_held", bus_if.div_by_zero, 1);

    run_op(3'b100, 16'd3, 16'd5, lat, bcnt);
    check("mul_clr_out", bus_if.out, 32'h0000_000F);
    check("mul_clr_dbz", bus_if.div_by_zero, 0);
    tick();

    // A divide request at cycle k+5 of a multiply must be dropped
    drive(3'b100, 16'h0102, 16'h0304);
    tick();
    bus_if.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    drive(3'b101, 16'd9, 16'd2);
    tick();
    bus_if.start = 1'b0;
    wait_done(lat, bcnt);
    check("mid_mul_out", bus_if.out, 32'h0003_0A08);
    check("mid_mul_lat", lat, mul_lat(16'h0304) - 5);
    tick();
    check("mid_mul_no_second", bus_if.busy | bus_if.done, 0);

    // start held high through MUL and DONE: second op accepted on the DONE edge
    drive(3'b100, 16'd7, 16'd6);
    tick();
    drive(3'b101, 16'd200, 16'd10);
    wait_done(lat, bcnt);
    check("b2b_first_out", bus_if.out, 32'h0000_002A);
    check("b2b_first_lat", lat, mul_lat(16'd6));
    tick();
    bus_if.start = 1'b0;
    check("b2b_busy_rise", bus_if.busy, 1);
    check("b2b_done_low", bus_if.done, 0);
    wait_done(lat, bcnt);
    check("b2b_second_out", bus_if.out, 32'h0000_0014);
    check("b2b_second_lat", lat, W);
    tick();

    drive(3'b101, 16'hF0F0, 16'h0003);
    tick();
    bus_if.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("abort_busy_before", bus_if.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", bus_if.busy, 0);
    check("abort_done", bus_if.done, 0);
    check("abort_out", bus_if.out, 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) seen++;
    end
    check("abort_no_done", seen, 0);

    run_op(3'b101, 16'hFFFF, 16'h0001, lat, bcnt);
    check("div_ffff_1_out", bus_if.out, 32'h0000_FFFF);
    check("div_ffff_1_lat", lat, W);
    tick();

    drive(3'b000, 16'h1111, 16'h2222);
    tick();
    bus_if.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) seen++;
      tick();
    end
    check("badfunc_idle", seen, 0);
    check("badfunc_out", bus_if.out, 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
